// File: rtl/jtopl_opreg_q.sv
// Per-slot operator register file with a single-entry write queue that commits
// when the slot scan reaches the target slot. Optional macro: JTOPL_WAVSEL_EN.
module jtopl_opreg_q #(
  parameter int unsigned NSLOT = 18,
  parameter int unsigned SW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [7:0]    din,
  input  logic          wr,
  input  logic [2:0]    wr_field,
  input  logic [SW-1:0] wr_slot,
  output logic          busy,
  output logic          overrun,
  output logic [SW-1:0] slot_idx,
  output logic          zero,
`ifdef JTOPL_WAVSEL_EN
  output logic [33:0]   cfg
`else
  output logic [31:0]   cfg
`endif
);

  localparam logic [SW:0]   NSLOT_W = (SW+1)'(NSLOT);
  localparam logic [SW-1:0] LAST    = SW'(NSLOT - 1);

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    q_din;
  logic [2:0]    q_field;
  logic [SW-1:0] q_slot;
  logic          field_ok;
  logic          slot_ok;
  logic          req;
  logic          commit;

  logic [31:0]   cfg_mem [NSLOT];
`ifdef JTOPL_WAVSEL_EN
  logic [1:0]    wav_mem [NSLOT];
`endif

  always_comb begin
`ifdef JTOPL_WAVSEL_EN
    field_ok = (wr_field <= 3'd4);
`else
    field_ok = (wr_field <= 3'd3);
`endif
    slot_ok = ({1'b0, wr_slot} < NSLOT_W);
    req     = wr & field_ok & slot_ok;
  end

  // Commit uses the registered queue state, so a write queued on the edge
  // where the scan sits on its target waits for the next visit.
  assign commit = cen & (state == PEND) & (slot_idx == q_slot);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = PEND;
      PEND:    if (commit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  assign busy = (state == PEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_din   <= '0;
      q_field <= '0;
      q_slot  <= '0;
    end else if (state == IDLE && req) begin
      q_din   <= din;
      q_field <= wr_field;
      q_slot  <= wr_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      overrun <= 1'b0;
    else if (state == PEND && req) overrun <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)               slot_idx <= '0;
    else if (cen) begin
      if (slot_idx == LAST) slot_idx <= '0;
      else                  slot_idx <= slot_idx + SW'(1);
    end
  end

  assign zero = (slot_idx == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSLOT; i++) cfg_mem[i] <= '0;
    end else if (commit) begin
      case (q_field)
        3'd0:    cfg_mem[q_slot][31:24] <= q_din;
        3'd1:    cfg_mem[q_slot][23:16] <= q_din;
        3'd2:    cfg_mem[q_slot][15:8]  <= q_din;
        3'd3:    cfg_mem[q_slot][7:0]   <= q_din;
        default: ;
      endcase
    end
  end

`ifdef JTOPL_WAVSEL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSLOT; i++) wav_mem[i] <= '0;
    end else if (commit && q_field == 3'd4) begin
      wav_mem[q_slot] <= q_din[1:0];
    end
  end

  always_comb cfg = {wav_mem[slot_idx], cfg_mem[slot_idx]};
`else
  always_comb cfg = cfg_mem[slot_idx];
`endif

endmodule

// File: tb/tb_jtopl_opreg_q.sv
// Self-checking bench for jtopl_opreg_q: slot-level behavioural model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_jtopl_opreg_q;

  localparam int NSLOT = 18;
  localparam int SW    = 6;
`ifdef JTOPL_WAVSEL_EN
  localparam int  CW  = 34;
  localparam bit  WAV = 1'b1;
`else
  localparam int  CW  = 32;
  localparam bit  WAV = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          cen;
  logic [7:0]    din;
  logic          wr;
  logic [2:0]    wr_field;
  logic [SW-1:0] wr_slot;
  logic          busy;
  logic          overrun;
  logic [SW-1:0] slot_idx;
  logic          zero;
  logic [CW-1:0] cfg;

  jtopl_opreg_q #(.NSLOT(NSLOT), .SW(SW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .wr(wr),
    .wr_field(wr_field), .wr_slot(wr_slot), .busy(busy),
    .overrun(overrun), .slot_idx(slot_idx), .zero(zero), .cfg(cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: four bytes plus wave select per slot, a pending-write
  // record, and the scan position.
  logic [7:0] m_b   [NSLOT][4];
  logic [1:0] m_wav [NSLOT];
  int  m_slot;
  bit  m_busy, m_ovr;
  int  m_qf, m_qs;
  logic [7:0] m_qd;

  always @(posedge clk) begin
    bit c, a;
    if (rst) begin
      for (int s = 0; s < NSLOT; s++) begin
        for (int k = 0; k < 4; k++) m_b[s][k] = 8'h00;
        m_wav[s] = 2'b00;
      end
      m_slot = 0; m_busy = 0; m_ovr = 0; m_qf = 0; m_qs = 0; m_qd = 0;
    end else begin
      c = cen && m_busy && (m_slot == m_qs);
      a = wr && (int'(wr_field) < 4 || (WAV && wr_field == 3'd4)) && int'(wr_slot) < NSLOT;
      if (c) begin
        if (m_qf < 4) m_b[m_qs][m_qf] = m_qd;
        else          m_wav[m_qs] = m_qd[1:0];
      end
      if (m_busy) begin
        if (a) m_ovr = 1;
        m_busy = !c;
      end else if (a) begin
        m_busy = 1; m_qf = int'(wr_field); m_qs = int'(wr_slot); m_qd = din;
      end
      if (cen) m_slot = (m_slot + 1) % NSLOT;
    end
  end

  function automatic logic [63:0] exp_cfg(input int s);
    logic [63:0] v;
    v = {m_b[s][0], m_b[s][1], m_b[s][2], m_b[s][3]};
    if (WAV) v[33:32] = m_wav[s];
    return v;
  endfunction

  always @(negedge clk) begin
    if (run) begin
      chk("m_slot",    64'(slot_idx), 64'(m_slot));
      chk("m_zero",    64'(zero),     64'(m_slot == 0));
      chk("m_busy",    64'(busy),     64'(m_busy));
      chk("m_overrun", 64'(overrun),  64'(m_ovr));
      chk("m_cfg",     64'(cfg),      exp_cfg(m_slot));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wr_req(input int f, input int s, input logic [7:0] d);
    wr = 1'b1; wr_field = 3'(f); wr_slot = SW'(s); din = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_slot(input int s);
    int n = 0;
    while (int'(slot_idx) != s && n < 100) begin tick(); n++; end
    if (n >= 100) chk("wait_slot_timeout", 64'(slot_idx), 64'(s));
  endtask

  task automatic wait_idle(input string name, input int exp_n);
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    chk(name, 64'(n), 64'(exp_n));
  endtask

  initial begin
    int s0;
    rst = 1'b1; cen = 1'b0; wr = 1'b0; din = '0; wr_field = '0; wr_slot = '0;
    @(posedge clk);
    run = 1'b1;
    tick();
    rst = 1'b0; cen = 1'b1;
    chk("rst_slot", 64'(slot_idx), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_cfg", 64'(cfg), 64'd0);

    // 40-clock scan
    for (int i = 0; i < 40; i++) begin
      chk("scan_slot", 64'(slot_idx), 64'(i % 18));
      chk("scan_zero", 64'(zero), 64'((i % 18) == 0));
      tick();
    end

    // Reserved field / out-of-range slot ignored
    wr_req(6, 1, 8'hFF);
    chk("rsvd_busy", 64'(busy), 64'd0);
    wr_req(0, 20, 8'hFF);
    chk("range_busy", 64'(busy), 64'd0);
    chk("range_overrun", 64'(overrun), 64'd0);
    wait_slot(1);
    chk("rsvd_cfg1", 64'(cfg[31:0]), 64'd0);

    // Wave select write
    wr_req(4, 0, 8'hFF);
`ifdef JTOPL_WAVSEL_EN
    chk("wav_busy", 64'(busy), 64'd1);
    wait_idle("wav_wait_bounded_ok", int'(busy) * 0 + 0 + ((NSLOT + 0 - int'(slot_idx)) % NSLOT) + 1);
    wait_slot(0);
    chk("wav_cfg", 64'(cfg[33:32]), 64'd3);
`else
    chk("wav_ignored_busy", 64'(busy), 64'd0);
    chk("wav_ignored_overrun", 64'(overrun), 64'd0);
`endif

    // Field 1 to slot 5 queued while scan at slot 2
    wait_slot(2);
    wr_req(1, 5, 8'h3F);
    chk("q5_busy", 64'(busy), 64'd1);
    wait_idle("q5_wait", 3);
    wait_slot(5);
    chk("q5_cfg", 64'(cfg[31:0]), 64'h003F0000);

    // Queued while scan already on target: full revolution wait
    wait_slot(9);
    wr_req(3, 9, 8'h5A);
    wait_idle("same_slot_wait", 18);
    wait_slot(9);
    chk("same_slot_cfg", 64'(cfg[7:0]), 64'h5A);

    // New write on the edge the queued one commits is dropped
    wait_slot(6);
    wr_req(3, 7, 8'h12);
    wr_req(3, 8, 8'h34);
    chk("commit_edge_busy", 64'(busy), 64'd0);
    chk("commit_edge_overrun", 64'(overrun), 64'd1);
    wait_slot(8);
    chk("commit_edge_slot8", 64'(cfg[7:0]), 64'h00);
    wait_slot(7);
    chk("commit_edge_slot7", 64'(cfg[7:0]), 64'h12);

    // Freeze with cen=0, then reset discards the pending write
    wr_req(0, 10, 8'hC3);
    cen = 1'b0;
    s0 = int'(slot_idx);
    repeat (50) tick();
    chk("freeze_busy", 64'(busy), 64'd1);
    chk("freeze_slot", 64'(slot_idx), 64'(s0));
    rst = 1'b1;
    tick();
    rst = 1'b0; cen = 1'b1;
    chk("rst2_busy", 64'(busy), 64'd0);
    chk("rst2_slot", 64'(slot_idx), 64'd0);
    chk("rst2_overrun", 64'(overrun), 64'd0);
    for (int i = 0; i < NSLOT; i++) begin
      chk("rst2_cfg", 64'(cfg), 64'd0);
      tick();
    end

    // Back-to-back writes: second dropped
    wr_req(0, 3, 8'hA5);
    wr_req(2, 4, 8'h77);
    chk("b2b_overrun", 64'(overrun), 64'd1);
    chk("b2b_busy", 64'(busy), 64'd1);
    wait_slot(4);
    wait_slot(3);
    chk("b2b_cfg3", 64'(cfg[31:0]), 64'hA5000000);
    wait_slot(4);
    chk("b2b_cfg4", 64'(cfg[31:0]), 64'h00000000);

    // Mixed traffic with cen gaps, checked by the model
    for (int i = 0; i < 300; i++) begin
      cen = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 2) == 0);
      wr_field = 3'($urandom_range(0, 7));
      wr_slot = SW'($urandom_range(0, 23));
      din = 8'($urandom);
      tick();
    end
    wr = 1'b0; cen = 1'b1;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
